// File: rtl/soc_system_cpu_0_div_pkg.sv
// Shared types and constants for the cpu_0 radix-2 restoring divider.
package soc_system_cpu_0_div_pkg;
  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_t;

  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_QUOT = '1;
  localparam logic [DIV_DATA_W-1:0] INT_MIN = {1'b1, {(DIV_DATA_W-1){1'b0}}};
endpackage

// File: rtl/soc_system_cpu_0_cpu_div_cell_if.sv
// Execute/memory-stage handshake between the cpu_0 pipeline and its divider.
interface soc_system_cpu_0_cpu_div_cell_if
  import soc_system_cpu_0_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);
  logic [DATA_W-1:0] E_src1;
  logic [DATA_W-1:0] E_src2;
  logic              E_div_start;
  logic              E_div_signed;
  logic              M_div_kill;
  logic              M_div_busy;
  logic              M_div_done;
  logic [DATA_W-1:0] M_div_quot;
  logic [DATA_W-1:0] M_div_rem;

  modport master (
    output E_src1, E_src2, E_div_start, E_div_signed, M_div_kill,
    input  M_div_busy, M_div_done, M_div_quot, M_div_rem
  );

  modport slave (
    input  E_src1, E_src2, E_div_start, E_div_signed, M_div_kill,
    output M_div_busy, M_div_done, M_div_quot, M_div_rem
  );
endinterface

// File: rtl/soc_system_cpu_0_cpu_div_step.sv
// One restoring-division iteration: shift {prem,dvd} left, trial-subtract, select.
module soc_system_cpu_0_cpu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] prem,
  input  logic [DATA_W-1:0] dvd,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] prem_nxt,
  output logic [DATA_W-1:0] dvd_nxt
);
  logic [DATA_W:0] prem_sh;
  logic [DATA_W:0] trial;
  logic            fits;

  assign prem_sh = {prem, dvd[DATA_W-1]};
  assign trial   = prem_sh - {1'b0, divisor};
  // A set carry-out bit in the shifted remainder guarantees it exceeds any divisor.
  assign fits    = prem_sh[DATA_W] | ~trial[DATA_W];

  always_comb begin
    prem_nxt = prem_sh[DATA_W-1:0];
    dvd_nxt  = {dvd[DATA_W-2:0], 1'b0};
    if (fits) begin
      prem_nxt = trial[DATA_W-1:0];
      dvd_nxt  = {dvd[DATA_W-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/soc_system_cpu_0_cpu_div_cell.sv
// Multi-cycle signed/unsigned integer divider for cpu_0, one quotient bit per clock.
// Define SOC_SYSTEM_CPU_0_DIV_FAST_EN to short-cut trivial operands straight to FIX.
module soc_system_cpu_0_cpu_div_cell
  import soc_system_cpu_0_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input logic clk,
  input logic reset_n,
  soc_system_cpu_0_cpu_div_cell_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_t        state, state_nxt;
  logic              busy, busy_nxt, done, done_nxt;
  logic              quot_neg, quot_neg_nxt, rem_neg, rem_neg_nxt;
  logic [DATA_W-1:0] quot, quot_nxt, rem, rem_nxt;
  logic [DATA_W-1:0] prem, prem_nxt, dvd, dvd_nxt, dsr, dsr_nxt;
  logic [DATA_W-1:0] step_prem, step_dvd, src1_mag, src2_mag;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              src1_neg, src2_neg;

  assign src1_neg = bus.E_div_signed & bus.E_src1[DATA_W-1];
  assign src2_neg = bus.E_div_signed & bus.E_src2[DATA_W-1];
  assign src1_mag = src1_neg ? -bus.E_src1 : bus.E_src1;
  assign src2_mag = src2_neg ? -bus.E_src2 : bus.E_src2;

  soc_system_cpu_0_cpu_div_step #(.DATA_W(DATA_W)) u_step (
    .prem     (prem),
    .dvd      (dvd),
    .divisor  (dsr),
    .prem_nxt (step_prem),
    .dvd_nxt  (step_dvd)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      prem     <= '0;
      dvd      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      quot     <= quot_nxt;
      rem      <= rem_nxt;
      prem     <= prem_nxt;
      dvd      <= dvd_nxt;
      dsr      <= dsr_nxt;
      cnt      <= cnt_nxt;
      quot_neg <= quot_neg_nxt;
      rem_neg  <= rem_neg_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    quot_nxt     = quot;
    rem_nxt      = rem;
    prem_nxt     = prem;
    dvd_nxt      = dvd;
    dsr_nxt      = dsr;
    cnt_nxt      = cnt;
    quot_neg_nxt = quot_neg;
    rem_neg_nxt  = rem_neg;
    if (bus.M_div_kill) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.E_div_start) begin
            dvd_nxt      = src1_mag;
            dsr_nxt      = src2_mag;
            prem_nxt     = '0;
            cnt_nxt      = CNT_W'(DATA_W);
            // Divide-by-zero keeps an all-ones quotient regardless of dividend sign.
            quot_neg_nxt = (src1_neg ^ src2_neg) & (bus.E_src2 != '0);
            rem_neg_nxt  = src1_neg;
            busy_nxt     = 1'b1;
            state_nxt    = CALC;
`ifdef SOC_SYSTEM_CPU_0_DIV_FAST_EN
            if (src2_mag == '0) begin
              dvd_nxt   = '1;
              prem_nxt  = src1_mag;
              cnt_nxt   = '0;
              state_nxt = FIX;
            end else if (src2_mag == DATA_W'(1)) begin
              dvd_nxt   = src1_mag;
              prem_nxt  = '0;
              cnt_nxt   = '0;
              state_nxt = FIX;
            end else if (src1_mag < src2_mag) begin
              dvd_nxt   = '0;
              prem_nxt  = src1_mag;
              cnt_nxt   = '0;
              state_nxt = FIX;
            end
`endif
          end
        end
        CALC: begin
          prem_nxt = step_prem;
          dvd_nxt  = step_dvd;
          cnt_nxt  = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = FIX;
        end
        FIX: begin
          quot_nxt  = quot_neg ? -dvd : dvd;
          rem_nxt   = rem_neg ? -prem : prem;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.M_div_busy = busy;
  assign bus.M_div_done = done;
  assign bus.M_div_quot = quot;
  assign bus.M_div_rem  = rem;
endmodule

// File: tb/tb_soc_system_cpu_0_cpu_div_cell.sv
// Self-checking bench for the cpu_0 divider: vector table plus kill/reset/back-to-back sequences.
`timescale 1ns/1ps
module tb_soc_system_cpu_0_cpu_div_cell;
  import soc_system_cpu_0_div_pkg::*;

  localparam int W = DIV_DATA_W;
`ifdef SOC_SYSTEM_CPU_0_DIV_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int NV = 13;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat_cnt = 0;
  int   busy_cnt = 0;
  exp_t sb[$];
  vec_t vecs[NV];

  soc_system_cpu_0_cpu_div_cell_if #(.DATA_W(W)) bus ();

  soc_system_cpu_0_cpu_div_cell #(.DATA_W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lat_cnt++;
    if (bus.M_div_busy) busy_cnt++;
  endtask

  function automatic int lat_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    logic [W-1:0] am, bm;
    am = (sgn && a[W-1]) ? -a : a;
    bm = (sgn && b[W-1]) ? -b : b;
    return (FAST && (bm == '0 || bm == W'(1) || am < bm)) ? 2 : W + 2;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input logic [W-1:0] q, input logic [W-1:0] r, input bit push);
    exp_t e;
    bus.E_src1 = a;
    bus.E_src2 = b;
    bus.E_div_signed = sgn;
    bus.E_div_start = 1'b1;
    if (push) begin
      e.q = q;
      e.r = r;
      sb.push_back(e);
    end
    lat_cnt = 0;
    busy_cnt = 0;
    tick();
    bus.E_div_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    exp_t e;
    while (!bus.M_div_done && lat_cnt < 200) tick();
    if (!bus.M_div_done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
      if (sb.size() > 0) e = sb.pop_front();
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_done actual=done required=no_done", name);
    end else begin
      e = sb.pop_front();
      check({name, "_quot"}, bus.M_div_quot, e.q);
      check({name, "_rem"}, bus.M_div_rem, e.r);
      check({name, "_latency"}, W'(lat_cnt), W'(exp_lat));
      check({name, "_busy_cycles"}, W'(busy_cnt), W'(exp_lat - 1));
    end
  endtask

  task automatic count_dones(input string name, input int n);
    int nd;
    nd = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.M_div_done) nd++;
    end
    check(name, W'(nd), '0);
  endtask

  initial begin
    vecs[0]  = '{32'd100,       32'd7,          1'b0, 32'd14,        32'd2};
    vecs[1]  = '{32'hFFFFFF9C,  32'd7,          1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE};
    vecs[2]  = '{INT_MIN,       32'hFFFFFFFF,   1'b1, INT_MIN,       32'd0};
    vecs[3]  = '{32'h12345678,  32'd0,          1'b0, DIV_ZERO_QUOT, 32'h12345678};
    vecs[4]  = '{32'd100,       32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,  32'd2};
    vecs[5]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,   1'b1, 32'd14,        32'hFFFFFFFE};
    vecs[6]  = '{32'hFFFFFF9C,  32'd7,          1'b0, 32'h24924916,  32'd2};
    vecs[7]  = '{32'd5,         32'd9,          1'b0, 32'd0,         32'd5};
    vecs[8]  = '{32'hDEADBEEF,  32'd1,          1'b0, 32'hDEADBEEF,  32'd0};
    vecs[9]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,   1'b0, 32'd1,         32'd0};
    vecs[10] = '{32'hFFFFFFF9,  32'd0,          1'b1, DIV_ZERO_QUOT, 32'hFFFFFFF9};
    vecs[11] = '{32'd1000,      32'd3,          1'b0, 32'd333,       32'd1};
    vecs[12] = '{32'd7,         32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,  32'd1};

    bus.E_src1 = '0;
    bus.E_src2 = '0;
    bus.E_div_start = 1'b0;
    bus.E_div_signed = 1'b0;
    bus.M_div_kill = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", W'(bus.M_div_busy), '0);
    check("reset_done", W'(bus.M_div_done), '0);
    check("reset_quot", bus.M_div_quot, '0);
    check("reset_rem", bus.M_div_rem, '0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].q, vecs[i].r, 1'b1);
      wait_done($sformatf("vec%0d", i), lat_of(vecs[i].a, vecs[i].b, vecs[i].sgn));
      tick();
      check($sformatf("vec%0d_done_pulse", i), W'(bus.M_div_done), '0);
      check($sformatf("vec%0d_quot_held", i), bus.M_div_quot, vecs[i].q);
    end

    // Kill mid-operation: no done, results of the previous op stay visible.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b1);
    wait_done("pre_kill", W + 2);
    issue(32'd1000, 32'd3, 1'b0, '0, '0, 1'b0);
    repeat (9) tick();
    bus.M_div_kill = 1'b1;
    tick();
    bus.M_div_kill = 1'b0;
    check("kill_busy", W'(bus.M_div_busy), '0);
    check("kill_done", W'(bus.M_div_done), '0);
    count_dones("kill_no_done", 40);
    check("kill_quot_held", bus.M_div_quot, 32'd14);
    check("kill_rem_held", bus.M_div_rem, 32'd2);

    // Reset in the middle of an operation.
    issue(32'd1000, 32'd3, 1'b0, '0, '0, 1'b0);
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    check("midrst_busy", W'(bus.M_div_busy), '0);
    check("midrst_done", W'(bus.M_div_done), '0);
    check("midrst_quot", bus.M_div_quot, '0);
    check("midrst_rem", bus.M_div_rem, '0);
    reset_n = 1'b1;
    tick();

    // Start while busy is ignored and not queued.
    issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b1);
    repeat (4) tick();
    bus.E_src1 = 32'd50;
    bus.E_src2 = 32'd5;
    bus.E_div_start = 1'b1;
    tick();
    bus.E_div_start = 1'b0;
    wait_done("busy_start", W + 2);
    count_dones("busy_start_not_queued", 40);

    // Start accepted in the done cycle.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b1);
    wait_done("b2b_first", W + 2);
    issue(32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b1);
    wait_done("b2b_second", W + 2);

    // Kill and start together in IDLE: nothing begins.
    bus.E_src1 = 32'd1000;
    bus.E_src2 = 32'd3;
    bus.E_div_signed = 1'b0;
    bus.E_div_start = 1'b1;
    bus.M_div_kill = 1'b1;
    tick();
    bus.E_div_start = 1'b0;
    bus.M_div_kill = 1'b0;
    check("killstart_busy", W'(bus.M_div_busy), '0);
    count_dones("killstart_no_done", 40);
    check("killstart_quot_held", bus.M_div_quot, 32'hFFFFFFF2);
    check("killstart_rem_held", bus.M_div_rem, 32'hFFFFFFFE);

    check("scoreboard_drained", W'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/soc_system_cpu_0_cpu_div_cell.md
Name: soc_system_cpu_0_cpu_div_cell

Overview:
- Multi-cycle radix-2 restoring integer divider for the cpu_0 execute/memory pipeline.
- It is the inverse-operation counterpart to the 16x16 partial-product multiplier cell.
- Takes E_src1 (dividend) and E_src2 (divisor) on a start pulse and iterates one quotient bit per clock.
- Returns quotient and remainder with a one-cycle done strobe; the pipeline stalls on busy.

Parameters:
- DATA_W, 32, operand/quotient/remainder width (power of two, >=8).
- CNT_W, $clog2(DATA_W)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  reset; synchronous, active-low.
- E_src1  in  DATA_W  dividend.
- E_src2  in  DATA_W  divisor.
- E_div_start  in  1  one-cycle request; sampled only in IDLE.
- E_div_signed  in  1  1 = signed (div), 0 = unsigned (divu); sampled with start.
- M_div_kill  in  1  pipeline flush; aborts any operation.
- M_div_busy  out  1  high from the cycle after an accepted start until done.
- M_div_done  out  1  one-cycle strobe; results valid this cycle and held until next accepted start.
- M_div_quot  out  DATA_W  quotient.
- M_div_rem  out  DATA_W  remainder.

Behaviour:
- Reset (reset_n low at posedge):
  - state=IDLE; busy=0; done=0; quot=0; rem=0; counter=0.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - On start && !kill, latch operands as magnitudes and record sign flags.
  - Signed mode only: quot_neg = src1[MSB]^src2[MSB]; rem_neg = src1[MSB].
  - Load partial remainder 0 and counter = DATA_W, then go to CALC.
  - busy=1 from the next cycle.
- CALC, once per cycle:
  - Shift {prem,dvd} left by 1.
  - trial = prem - divisor, computed DATA_W+1 bits wide.
  - If trial is non-negative: prem=trial and shift in quotient bit 1; else shift in 0.
  - Decrement counter; at counter==1 go to FIX.
- FIX:
  - Apply two's-complement negation per quot_neg/rem_neg.
  - Register the outputs, pulse done=1, drop busy=0, return to IDLE.
- Latency: start sampled at edge k; done high in the cycle after edge k+DATA_W+1, i.e. 34 cycles for DATA_W=32.
- Divide by zero (divisor==0):
  - quot = all ones.
  - rem = original dividend (sign preserved).
  - This falls out naturally from the iteration; no special path without the optional feature.
- Signed overflow (-2^(DATA_W-1) / -1): quot = 0x80000000, rem = 0, with no trap.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- start while busy: ignored, with no queueing.
- kill in any state: at the next edge go to IDLE, busy=0, done stays 0, and quot/rem keep their previous values.
- kill and start in the same IDLE cycle: kill wins and start is dropped.
- reset_n low mid-operation: full reset as above.
- start in the done cycle: accepted (state is already IDLE); done is a single cycle.

Optional Feature:
- Macro: SOC_SYSTEM_CPU_0_DIV_FAST_EN.
- When defined, IDLE checks for early-exit cases and jumps directly to FIX, so done comes 2 cycles after start:
  - divisor==0;
  - |dividend| < |divisor|, which gives quot=0 and rem=dividend;
  - divisor==1 magnitude, which gives quot=±dividend and rem=0.
- When undefined, every operation takes the full DATA_W+2 cycles; results are identical in both builds.

Decomposition:
- Shared package soc_system_cpu_0_div_pkg holds:
  - the state enum (IDLE, CALC, FIX);
  - DATA_W default;
  - constants DIV_ZERO_QUOT (all ones) and INT_MIN.
- One natural sub-module, soc_system_cpu_0_cpu_div_step: combinational single-iteration shift/subtract/select.
  - Inputs: prem, dvd, divisor. Outputs: next prem, next dvd.
  - Verified standalone and reused if a radix-4 variant is built later.

Test Plan:
- Unsigned 100 / 7: quot=14, rem=2; done exactly 34 cycles after start; busy high for 33 cycles.
- Signed -100 / 7: quot=0xFFFFFFF2 (-14), rem=0xFFFFFFFE (-2).
- Signed 0x80000000 / 0xFFFFFFFF: quot=0x80000000, rem=0.
- Divide by zero, unsigned 0x12345678 / 0: quot=0xFFFFFFFF, rem=0x12345678.
  - Latency 34 cycles without the macro, 2 cycles with SOC_SYSTEM_CPU_0_DIV_FAST_EN.
- Mid-operation kill and reset:
  - Start 1000/3, assert kill at cycle 10: no done, busy=0 next cycle, outputs hold the previous result.
  - Start again then drop reset_n at cycle 5: all outputs read 0 after the edge.
- Back-to-back and ignored starts:
  - start asserted while busy: ignored, result matches the first operands.
  - start in the done cycle: accepted, second done 34 cycles later.
  - kill and start together in IDLE: no operation begins.
